// File: rtl/branch_resolve_pkg.sv
// Shared constants for branch resolution: funct3 codes,
// FSM states and flush counter sizing.
package branch_resolve_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIRECT,
    S_FLUSH
  } state_e;

  function automatic int flush_cw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition: funct3 + comparator flags
// to taken / illegal.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_jump,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       taken,
  output logic       illegal
);

  logic cond;
  logic bad;

  always_comb begin
    cond = 1'b0;
    bad  = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = br_eq;
      F3_BNE:  cond = !br_eq;
      F3_BLT:  cond = br_lt;
      F3_BGE:  cond = !br_lt;
      F3_BLTU: cond = br_ltu;
      F3_BGEU: cond = !br_ltu;
      default: bad  = 1'b1;
    endcase
  end

  assign taken   = is_jump | cond;
  assign illegal = !is_jump & bad;

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve: redirect handshake to fetch, then flush.
// Optional statistics counters under BRANCH_STATS_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [2:0]       io_funct3,
  input  logic             io_is_jump,
  input  logic             io_br_eq,
  input  logic             io_br_lt,
  input  logic             io_br_ltu,
  input  logic [XLEN-1:0]  io_target,
  output logic             io_redir_valid,
  input  logic             io_redir_ready,
  output logic [XLEN-1:0]  io_redir_pc,
  output logic             io_flush,
  output logic             io_misalign,
  output logic             io_illegal,
  output logic [CNT_W-1:0] io_taken_cnt,
  output logic [CNT_W-1:0] io_nottaken_cnt
);

  localparam int FCW = flush_cw(FLUSH_CYCLES);
  localparam logic [FCW-1:0] FLOAD = FCW'(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;

  logic taken;
  logic illegal;
  logic accept;
  logic aligned;

  branch_cond u_cond (
    .funct3  (io_funct3),
    .is_jump (io_is_jump),
    .br_eq   (io_br_eq),
    .br_lt   (io_br_lt),
    .br_ltu  (io_br_ltu),
    .taken   (taken),
    .illegal (illegal)
  );

  assign io_in_ready = (state_q == S_IDLE);
  assign accept      = io_in_valid & io_in_ready;
  assign aligned     = (io_target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fcnt_d     = fcnt_q;
    misalign_d = 1'b0;
    illegal_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          illegal_d = illegal;
          if (taken && aligned) begin
            pc_d    = io_target;
            state_d = S_REDIRECT;
          end else if (taken) begin
            misalign_d = 1'b1;
          end
        end
      end
      S_REDIRECT: begin
        if (io_redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = FLOAD;
          end
        end
      end
      S_FLUSH: begin
        if (fcnt_q <= FCW'(1)) state_d = S_IDLE;
        else fcnt_d = fcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      fcnt_q     <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fcnt_q     <= fcnt_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

  assign io_redir_valid = (state_q == S_REDIRECT);
  assign io_redir_pc    = pc_q;
  // Flush also covers the handshake cycle itself
  assign io_flush    = (state_q == S_FLUSH)
                     | (io_redir_valid & io_redir_ready);
  assign io_misalign = misalign_q;
  assign io_illegal  = illegal_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] ncnt_q, ncnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    ncnt_d = ncnt_q;
    if (accept && taken && aligned && tcnt_q != '1)
      tcnt_d = tcnt_q + 1'b1;
    if (accept && !taken && !illegal && ncnt_q != '1)
      ncnt_d = ncnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      ncnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      ncnt_q <= ncnt_d;
    end
  end

  assign io_taken_cnt    = tcnt_q;
  assign io_nottaken_cnt = ncnt_q;
`else
  assign io_taken_cnt    = '0;
  assign io_nottaken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [2:0]       io_funct3 = 3'b000;
  logic             io_is_jump = 1'b0;
  logic             io_br_eq = 1'b0;
  logic             io_br_lt = 1'b0;
  logic             io_br_ltu = 1'b0;
  logic [XLEN-1:0]  io_target = '0;
  logic             io_redir_valid;
  logic             io_redir_ready = 1'b0;
  logic [XLEN-1:0]  io_redir_pc;
  logic             io_flush;
  logic             io_misalign;
  logic             io_illegal;
  logic [CNT_W-1:0] io_taken_cnt;
  logic [CNT_W-1:0] io_nottaken_cnt;

  int checks = 0;
  int failures = 0;

  branch_resolve #(
    .XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_funct3(io_funct3), .io_is_jump(io_is_jump),
    .io_br_eq(io_br_eq), .io_br_lt(io_br_lt),
    .io_br_ltu(io_br_ltu), .io_target(io_target),
    .io_redir_valid(io_redir_valid),
    .io_redir_ready(io_redir_ready),
    .io_redir_pc(io_redir_pc), .io_flush(io_flush),
    .io_misalign(io_misalign), .io_illegal(io_illegal),
    .io_taken_cnt(io_taken_cnt),
    .io_nottaken_cnt(io_nottaken_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic present(input logic [2:0] f3, input logic j,
                         input logic eq, input logic lt,
                         input logic ltu,
                         input logic [31:0] tgt);
    io_in_valid = 1'b1;
    io_funct3   = f3;
    io_is_jump  = j;
    io_br_eq    = eq;
    io_br_lt    = lt;
    io_br_ltu   = ltu;
    io_target   = tgt;
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(io_in_ready), 1);
    chk("rst_valid", 32'(io_redir_valid), 0);
    chk("rst_pc", io_redir_pc, 0);
    chk("rst_flush", 32'(io_flush), 0);
    chk("rst_misal", 32'(io_misalign), 0);
    chk("rst_illeg", 32'(io_illegal), 0);
    chk("rst_tcnt", 32'(io_taken_cnt), 0);
    reset = 1'b1;
    step();

    // BEQ taken, fetch ready at once
    io_redir_ready = 1'b1;
    present(3'b000, 0, 1, 0, 0, 32'h100);
    #1 chk("beq_ready", 32'(io_in_ready), 1);
    step();
    io_in_valid = 1'b0;
    #1;
    chk("beq_valid", 32'(io_redir_valid), 1);
    chk("beq_pc", io_redir_pc, 32'h100);
    chk("beq_flush0", 32'(io_flush), 1);
    chk("beq_nrdy", 32'(io_in_ready), 0);
    step();
    chk("beq_flush1", 32'(io_flush), 1);
    chk("beq_vdrop", 32'(io_redir_valid), 0);
    step();
    chk("beq_flush2", 32'(io_flush), 1);
    step();
    chk("beq_flush3", 32'(io_flush), 0);
    chk("beq_rdy", 32'(io_in_ready), 1);
    chk("beq_tcnt", 32'(io_taken_cnt), st(1));

    // BGEU with ltu=1: not taken
    present(3'b111, 0, 0, 0, 1, 32'h300);
    step();
    io_in_valid = 1'b0;
    #1;
    chk("bgeu_valid", 32'(io_redir_valid), 0);
    chk("bgeu_rdy", 32'(io_in_ready), 1);
    chk("bgeu_ncnt", 32'(io_nottaken_cnt), st(1));

    // JAL to misaligned target
    present(3'b010, 1, 0, 0, 0, 32'h202);
    step();
    io_in_valid = 1'b0;
    #1;
    chk("jal_misal", 32'(io_misalign), 1);
    chk("jal_valid", 32'(io_redir_valid), 0);
    chk("jal_rdy", 32'(io_in_ready), 1);
    chk("jal_illeg", 32'(io_illegal), 0);
    step();
    chk("jal_misal_end", 32'(io_misalign), 0);
    chk("jal_tcnt", 32'(io_taken_cnt), st(1));

    // BNE taken, fetch stalls 5 cycles
    io_redir_ready = 1'b0;
    present(3'b001, 0, 0, 0, 0, 32'h400);
    step();
    present(3'b000, 1, 0, 0, 0, 32'h800);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bne_valid", 32'(io_redir_valid), 1);
      chk("bne_pc", io_redir_pc, 32'h400);
      chk("bne_nrdy", 32'(io_in_ready), 0);
      chk("bne_noflush", 32'(io_flush), 0);
      step();
    end
    io_redir_ready = 1'b1;
    io_in_valid = 1'b0;
    #1;
    chk("bne_hs_flush", 32'(io_flush), 1);
    chk("bne_hs_pc", io_redir_pc, 32'h400);
    step();
    chk("bne_flush1", 32'(io_flush), 1);
    chk("bne_vdrop", 32'(io_redir_valid), 0);
    step();
    step();
    chk("bne_idle", 32'(io_in_ready), 1);
    chk("bne_flush_end", 32'(io_flush), 0);
    chk("bne_tcnt", 32'(io_taken_cnt), st(2));

    // funct3=010 without jump
    present(3'b010, 0, 1, 1, 1, 32'h500);
    step();
    io_in_valid = 1'b0;
    #1;
    chk("ill_pulse", 32'(io_illegal), 1);
    chk("ill_valid", 32'(io_redir_valid), 0);
    step();
    chk("ill_end", 32'(io_illegal), 0);
    chk("ill_ncnt", 32'(io_nottaken_cnt), st(1));

    // Reset during REDIRECT
    io_redir_ready = 1'b0;
    present(3'b100, 0, 0, 1, 0, 32'h40);
    step();
    io_in_valid = 1'b0;
    #1;
    chk("blt_valid", 32'(io_redir_valid), 1);
    io_redir_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(io_redir_valid), 0);
    chk("arst_flush", 32'(io_flush), 0);
    chk("arst_pc", io_redir_pc, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_rdy", 32'(io_in_ready), 1);
    chk("post_valid", 32'(io_redir_valid), 0);
    chk("post_tcnt", 32'(io_taken_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
